de_pipe_reg: RTL
================

DE_PIPE_REG -- requirements
Module: de_pipe_reg

Interface
REQ-001 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have stall  input  1  hazard unit: D operand not ready; insert bubble into E.
REQ-004 SHALL have req  input  1  exception/interrupt/eret flush request from CP0.
REQ-005 SHALL have D_PC  input  32  PC of instruction in D.
REQ-006 SHALL have D_instr  input  32  instruction word in D.
REQ-007 SHALL have D_RD1, D_RD2  input  32 each  forwarded GRF read data from D.
REQ-008 SHALL have D_EXT  input  32  extended immediate.
REQ-009 SHALL have D_A3  input  5  destination register number (0 = no write).
REQ-010 SHALL have D_Tnew  input  2  cycles until result available, counted from E.
REQ-011 SHALL have D_BD  input  1  instruction sits in a branch delay slot.
REQ-012 SHALL have D_ExcCode  input  5  exception code raised in F/D (0 = none).
REQ-013 SHALL have E_PC, E_instr, E_RD1, E_RD2, E_EXT  output  32 each  registered copies.
REQ-014 SHALL have E_A3  output  5; E_Tnew  output  2; E_BD  output  1; E_ExcCode  output  5; registered copies.
REQ-015 SHALL have E_fwd_ok  output  1  combinational: E_Tnew==0 and E_A3!=0.

Function
REQ-016 SHALL update all E_* registers every rising edge by exactly one of: reset, flush, bubble, load; priority reset > req > stall > load.
REQ-017 Load (no reset/req/stall): every E_* register SHALL take its D_* input; latency one cycle.
REQ-018 Bubble (stall=1, req=0): E_instr, E_RD1, E_RD2, E_EXT, E_A3, E_Tnew, E_ExcCode SHALL clear to 0; E_PC SHALL take D_PC and E_BD SHALL take D_BD, so EPC/BD stay correct if an interrupt hits the bubble.
REQ-019 Flush (req=1, any stall): E_PC SHALL become 32'h0000_4180, E_BD 0, all other E_* 0.
REQ-020 Bubble and flush SHALL never produce E_A3!=0 or E_Tnew!=0, so a bubble cannot cause forwarding or a stall downstream.
REQ-021 E_Tnew SHALL be stored as given (no decrement here); decrement belongs to the E/M register.
REQ-022 D_A3==0 with D_Tnew!=0 SHALL be loaded unchanged; E_fwd_ok SHALL remain 0 for it.
REQ-023 Consecutive stall cycles SHALL produce one bubble per cycle, E_PC tracking D_PC each cycle.
REQ-024 Deasserting stall SHALL load the held D instruction on the next edge with no lost or duplicated instruction.

Reset
REQ-025 On reset=1 at a rising edge all E_* SHALL clear to 0, except E_PC = 32'h0000_3000.
REQ-026 Reset asserted mid-stall or with req SHALL win; no input is captured that cycle.
REQ-027 No state SHALL change between edges; outputs before first reset are don't-care.

Configuration
REQ-028 Macro DE_EXC_PATH_EN SHALL gate the exception fields.
REQ-029 With DE_EXC_PATH_EN defined: req, D_BD, D_ExcCode, E_BD, E_ExcCode SHALL exist and behave per REQ-016..026.
REQ-030 Without it: those ports SHALL be absent; req is treated as 0; REQ-019 does not apply; all other behaviour unchanged.

Verification
REQ-031 Reset then idle -> E_PC=0x3000, all other E_*=0, E_fwd_ok=0.
REQ-032 D_PC=0x3004, D_instr=0x8C41_0004, D_A3=1, D_Tnew=2, no stall -> next edge E_* equal inputs, E_fwd_ok=0; repeat with D_Tnew=0 -> E_fwd_ok=1.
REQ-033 stall=1 for 2 cycles with D_PC=0x3010, D_BD=1 -> E_instr=0, E_A3=0, E_PC=0x3010, E_BD=1 both cycles; stall=0 -> E_instr=D_instr next edge.
REQ-034 req=1 together with stall=1 -> E_PC=0x4180, E_BD=0, all else 0.
REQ-035 reset=1 together with req=1 and stall=1 -> E_PC=0x3000, all else 0.
REQ-036 Build without DE_EXC_PATH_EN -> REQ-032/033 pass; exception ports absent from elaboration.

Source files
------------

// File: rtl/de_pipe_reg.sv
// ---------------------------------------------------------------------------
// de_pipe_reg -- D/E pipeline register of the five-stage MIPS core.
//
// Every rising edge the E-stage copy is updated by exactly one of the
// following actions, listed from highest to lowest priority:
//   reset : clear everything, E_PC = 0x0000_3000
//   flush : (req)   clear everything, E_PC = 0x0000_4180 (handler), E_BD = 0
//   bubble: (stall) clear everything except E_PC/E_BD, which follow D so that
//           an interrupt taken on the bubble still reports a correct EPC/BD
//   load  : copy all D_* inputs
// Bubbles and flushes always leave E_A3 = 0 and E_Tnew = 0, so they can never
// forward a value or stall anything downstream.
//
// Build option: define DE_EXC_PATH_EN to include the exception path
// (req, D_BD, D_ExcCode, E_BD, E_ExcCode). Without it those ports are absent
// and req behaves as if tied to 0.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   stall                 hazard unit: insert a bubble into E
//   req                   CP0 flush request              (DE_EXC_PATH_EN)
//   D_PC, D_instr         PC and instruction word in D
//   D_RD1, D_RD2, D_EXT   forwarded register data, extended immediate
//   D_A3, D_Tnew          destination register, cycles until result ready
//   D_BD, D_ExcCode       delay-slot flag, F/D exception  (DE_EXC_PATH_EN)
//   E_*                   registered copies of the above
//   E_fwd_ok              E result is ready now and targets a real register
// ---------------------------------------------------------------------------
module de_pipe_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
`ifdef DE_EXC_PATH_EN
  input  logic        req,
`endif
  input  logic [31:0] D_PC,
  input  logic [31:0] D_instr,
  input  logic [31:0] D_RD1,
  input  logic [31:0] D_RD2,
  input  logic [31:0] D_EXT,
  input  logic [4:0]  D_A3,
  input  logic [1:0]  D_Tnew,
`ifdef DE_EXC_PATH_EN
  input  logic        D_BD,
  input  logic [4:0]  D_ExcCode,
`endif
  output logic [31:0] E_PC,
  output logic [31:0] E_instr,
  output logic [31:0] E_RD1,
  output logic [31:0] E_RD2,
  output logic [31:0] E_EXT,
  output logic [4:0]  E_A3,
  output logic [1:0]  E_Tnew,
`ifdef DE_EXC_PATH_EN
  output logic        E_BD,
  output logic [4:0]  E_ExcCode,
`endif
  output logic        E_fwd_ok
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] FLUSH_PC = 32'h0000_4180;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext;
    logic [4:0]  a3;
    logic [1:0]  tnew;
`ifdef DE_EXC_PATH_EN
    logic        bd;
    logic [4:0]  exc_code;
`endif
  } e_regs_t;

  e_regs_t e_d;
  e_regs_t e_q;
  logic    flush;

`ifdef DE_EXC_PATH_EN
  assign flush = req;
`else
  assign flush = 1'b0;
`endif

  // Next state for the non-reset actions; reset is applied in the register.
  always_comb begin
    // NOTE: default every field first; any path that skips a field then
    // yields 0 instead of an inferred latch, which is exactly the bubble/flush value.
    e_d = '0;
    if (flush) begin
      e_d.pc = FLUSH_PC;
    end else if (stall) begin
      // Bubble keeps PC/BD of the held instruction for precise EPC.
      e_d.pc = D_PC;
`ifdef DE_EXC_PATH_EN
      e_d.bd = D_BD;
`endif
    end else begin
      e_d.pc    = D_PC;
      e_d.instr = D_instr;
      e_d.rd1   = D_RD1;
      e_d.rd2   = D_RD2;
      e_d.ext   = D_EXT;
      e_d.a3    = D_A3;
      e_d.tnew  = D_Tnew;   // stored as given; E/M does the decrement
`ifdef DE_EXC_PATH_EN
      e_d.bd       = D_BD;
      e_d.exc_code = D_ExcCode;
`endif
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every reader sees
    // the pre-edge value regardless of process ordering.
    if (reset) begin
      e_q    <= '0;
      e_q.pc <= RESET_PC;
    end else begin
      e_q <= e_d;
    end
  end

  assign E_PC      = e_q.pc;
  assign E_instr   = e_q.instr;
  assign E_RD1     = e_q.rd1;
  assign E_RD2     = e_q.rd2;
  assign E_EXT     = e_q.ext;
  assign E_A3      = e_q.a3;
  assign E_Tnew    = e_q.tnew;
`ifdef DE_EXC_PATH_EN
  assign E_BD      = e_q.bd;
  assign E_ExcCode = e_q.exc_code;
`endif

  // A result can be forwarded from E only if it is already computed and
  // destined for a real register ($0 writes are discarded).
  assign E_fwd_ok  = (e_q.tnew == 2'd0) && (e_q.a3 != 5'd0);

endmodule
